// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern buffer and its serial loader.
package pattern_pkg;

  // Frame geometry shared with the pattern buffer.
  localparam int BUFFER_SIZE  = 22;
  localparam int BUFFER_WIDTH = 8;

  // A counter that must be able to hold the value n needs this many bits.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int BYTE_CNT_W = cnt_w(BUFFER_SIZE);
  localparam int BIT_CNT_W  = cnt_w(BUFFER_WIDTH);

  // Loader sequencing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_bit_shifter.sv
// Bit-level datapath of the loader: transmit and receive shift registers
// plus the bit counter for one field.
//   load     : capture load_data; its MSB appears on sin in the next cycle.
//   shift_en : one scan-chain shift happens at this edge; sout is sampled.
//   last     : the current shift cycle carries the final bit of the field.
//   rx_word  : received field including the bit being sampled this cycle.
module pattern_bit_shifter
  import pattern_pkg::*;
#(
  parameter int W = BUFFER_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         sout,
  output logic         sin,
  output logic         last,
  output logic [W-1:0] rx_word
);

  localparam int BCW = cnt_w(W);

  logic [W-1:0]   tx_sr_q, tx_sr_d;
  logic [W-1:0]   rx_sr_q, rx_sr_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           sin_q, sin_d;

  assign last    = (bit_cnt_q == BCW'(W - 1));
  assign rx_word = {rx_sr_q[W-2:0], sout};
  assign sin     = sin_q;

  // sin is kept as its own flop so the pin is registered; tx_sr holds the
  // bits still to be sent after the one currently on sin.
  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    sin_d     = sin_q;
    if (load) begin
      tx_sr_d   = {load_data[W-2:0], 1'b0};
      sin_d     = load_data[W-1];
      bit_cnt_d = '0;
    end else if (shift_en) begin
      rx_sr_d = {rx_sr_q[W-2:0], sout};
      if (last) begin
        bit_cnt_d = '0;
        sin_d     = 1'b0;
        tx_sr_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        sin_d     = tx_sr_q[W-1];
        tx_sr_d   = {tx_sr_q[W-2:0], 1'b0};
      end
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      sin_q     <= 1'b0;
    end else begin
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      sin_q     <= sin_d;
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// Serial programmer for the pattern buffer scan chain. Takes one frame of
// BUFFER_SIZE bytes over byte_valid/byte_ready, shifts each MSB-first into
// the chain and returns the displaced old contents on rd_byte/rd_valid.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high; byte_ready is high only in LOAD, byte_valid may
// stall for any number of cycles and byte_in is ignored while byte_ready=0.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int BUFFER_SIZE  = pattern_pkg::BUFFER_SIZE,
  parameter int BUFFER_WIDTH = pattern_pkg::BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BUFFER_WIDTH-1:0] byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rd_byte,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int BYW = cnt_w(BUFFER_SIZE);

  state_e                  state_q, state_d;
  logic [BYW-1:0]          byte_cnt_q, byte_cnt_d;
  logic                    byte_ready_q, byte_ready_d;
  logic                    ssel_q, ssel_d;
  logic [BUFFER_WIDTH-1:0] rd_byte_q, rd_byte_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic                    shift_en;
  logic                    last_bit;
  logic [BUFFER_WIDTH-1:0] rx_word;

  assign accept   = (state_q == ST_LOAD) && byte_valid && byte_ready_q;
  assign shift_en = (state_q == ST_SHIFT);

  pattern_bit_shifter #(.W(BUFFER_WIDTH)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (byte_in),
    .shift_en  (shift_en),
    .sout      (sout),
    .sin       (sin),
    .last      (last_bit),
    .rx_word   (rx_word)
  );

  // Frame sequencing; all outputs are decoded from the next state so that
  // every pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    rd_byte_d  = rd_byte_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byte_cnt_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          rd_byte_d  = rx_word;
          rd_valid_d = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_d == BYW'(BUFFER_SIZE)) state_d = ST_DONE;
          else                                 state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    byte_ready_d = (state_d == ST_LOAD);
    ssel_d       = (state_d == ST_SHIFT);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    done_d       = (state_d == ST_DONE);
  end

  // State and output registers; reset drops ssel without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      ssel_q       <= 1'b0;
      rd_byte_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_ready_q <= byte_ready_d;
      ssel_q       <= ssel_d;
      rd_byte_q    <= rd_byte_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign ssel       = ssel_q;
  assign rd_byte    = rd_byte_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader driving a behavioural pattern buffer scan chain.
module tb_pattern_loader;

  localparam int SZ = 22;
  localparam int W  = 8;
  localparam int CW = SZ * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         start = 1'b0;
  logic [W-1:0] byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_ready, ssel, sin, sout, rd_valid, busy, done;
  logic [W-1:0] rd_byte;

  pattern_loader #(.BUFFER_SIZE(SZ), .BUFFER_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ssel       (ssel),
    .sin        (sin),
    .sout       (sout),
    .rd_byte    (rd_byte),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- pattern buffer stand-in ----------------
  // Fields chained 0 -> SZ-1; sin enters field 0 LSB, sout is field SZ-1 MSB.
  logic [W-1:0] buf_mem [SZ];
  logic [W-1:0] pre_mem [SZ];
  logic         preload_req = 1'b0;

  assign sout = buf_mem[SZ-1][W-1];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < SZ; i++) buf_mem[i] <= pre_mem[i];
    end else if (ssel) begin
      buf_mem[0] <= {buf_mem[0][W-2:0], sin};
      for (int i = 1; i < SZ; i++) buf_mem[i] <= {buf_mem[i][W-2:0], buf_mem[i-1][W-1]};
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] got_q[$];
  int rdv_cnt = 0, done_pulses = 0, done_long = 0, ssel_cnt = 0;
  int sin_viol = 0, both_viol = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin got_q.push_back(rd_byte); rdv_cnt++; end
      if (done) done_pulses++;
      if (done && done_prev) done_long++;
      if (ssel) ssel_cnt++;
      if (!ssel && sin) sin_viol++;
      if (ssel && byte_ready) both_viol++;
    end
    done_prev = done;
  end

  // ---------------- reference model and scoreboard ----------------
  // The whole chain as one bit vector, field k at [8k+7:8k]; every bit sent
  // enters at the bottom and the top bit falls out.
  logic [CW-1:0] ref_chain;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  tx_bytes [SZ];

  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [W-1:0] offs, input logic [W-1:0] step);
    for (int k = 0; k < SZ; k++) begin
      pre_mem[k] = offs + step * W'(k);
      ref_chain[W*k +: W] = pre_mem[k];
    end
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic wait_ready(input string what);
    int guard = 0;
    while (byte_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL %s_timeout byte_ready=%b required=1", what, byte_ready);
    end
  endtask

  // Runs one frame of tx_bytes and checks readback, final buffer contents,
  // strobes, ssel budget and (without stalls) first-accept-to-done latency.
  task automatic send_frame(input bit stall, input int inj, input string tag);
    logic [CW-1:0] old;
    int base, d0, dl0, r0, s0, sv0, bv0, acc_cyc, done_cyc, guard;
    old  = ref_chain;
    base = got_q.size();
    exp_q.delete();
    for (int k = 0; k < SZ; k++) exp_q.push_back(old[CW-1-W*k -: W]);
    d0 = done_pulses; dl0 = done_long; r0 = rdv_cnt; s0 = ssel_cnt;
    sv0 = sin_viol; bv0 = both_viol; acc_cyc = 0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < SZ; k++) begin
      if (stall && (k % 3 == 0)) begin
        wait_ready("stall");
        byte_valid = 1'b0;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (ssel !== 1'b0) begin bad++; $display("FAIL %s_stall_ssel byte=%0d ssel=%b required=0", tag, k, ssel); end
        end
      end
      byte_in    = tx_bytes[k];
      byte_valid = 1'b1;
      wait_ready(tag);
      if (k == 0) acc_cyc = cyc;
      @(negedge clk);
      if (k == inj) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    byte_valid = 1'b0;
    byte_in    = W'($urandom);

    guard = 0;
    while (done !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    done_cyc = cyc;
    total++;
    if (guard >= 100) begin bad++; $display("FAIL %s_done_timeout done=%b required=1", tag, done); end
    @(negedge clk);

    for (int k = 0; k < SZ; k++) ref_chain = {ref_chain[CW-W-1:0], tx_bytes[k]};

    for (int k = 0; k < SZ; k++) begin
      total++;
      if (base + k >= got_q.size()) begin
        bad++; $display("FAIL %s_readback k=%0d missing required=%0h", tag, k, exp_q[k]);
      end else if (got_q[base+k] !== exp_q[k]) begin
        bad++; $display("FAIL %s_readback k=%0d got=%0h required=%0h", tag, k, got_q[base+k], exp_q[k]);
      end
    end
    for (int i = 0; i < SZ; i++) begin
      total++;
      if (buf_mem[i] !== ref_chain[W*i +: W]) begin
        bad++; $display("FAIL %s_field i=%0d got=%0h required=%0h", tag, i, buf_mem[i], ref_chain[W*i +: W]);
      end
    end
    total++;
    if (rdv_cnt - r0 != SZ) begin bad++; $display("FAIL %s_rd_valid_count got=%0d required=%0d", tag, rdv_cnt - r0, SZ); end
    total++;
    if (done_pulses - d0 != 1) begin bad++; $display("FAIL %s_done_count got=%0d required=1", tag, done_pulses - d0); end
    total++;
    if (done_long != dl0) begin bad++; $display("FAIL %s_done_width extra_cycles=%0d required=0", tag, done_long - dl0); end
    total++;
    if (ssel_cnt - s0 != SZ * W) begin bad++; $display("FAIL %s_ssel_cycles got=%0d required=%0d", tag, ssel_cnt - s0, SZ * W); end
    total++;
    if (sin_viol != sv0) begin bad++; $display("FAIL %s_sin_idle got=%0d required=0", tag, sin_viol - sv0); end
    total++;
    if (both_viol != bv0) begin bad++; $display("FAIL %s_ready_and_ssel got=%0d required=0", tag, both_viol - bv0); end
    if (!stall) begin
      total++;
      if (done_cyc - acc_cyc != SZ * (W + 1)) begin
        bad++; $display("FAIL %s_latency got=%0d required=%0d", tag, done_cyc - acc_cyc, SZ * (W + 1));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total += 7;
    if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready got=%b required=0", byte_ready); end
    if (ssel !== 1'b0)       begin bad++; $display("FAIL reset_ssel got=%b required=0", ssel); end
    if (sin !== 1'b0)        begin bad++; $display("FAIL reset_sin got=%b required=0", sin); end
    if (rd_byte !== 8'h00)   begin bad++; $display("FAIL reset_rd_byte got=%0h required=0", rd_byte); end
    if (rd_valid !== 1'b0)   begin bad++; $display("FAIL reset_rd_valid got=%b required=0", rd_valid); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b required=0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b byte_ready=%b required=0", busy, byte_ready);
    end
  endtask

  task automatic test_full_frame();
    preload(8'h00, 8'h01);
    for (int k = 0; k < SZ; k++) tx_bytes[k] = 8'hA0 + W'(k);
    send_frame(1'b0, -1, "full_frame");
  endtask

  task automatic test_stalls();
    preload(8'h00, 8'h01);
    for (int k = 0; k < SZ; k++) tx_bytes[k] = 8'hA0 + W'(k);
    send_frame(1'b1, -1, "stalls");
  endtask

  task automatic test_ssel_count();
    for (int k = 0; k < SZ; k++) tx_bytes[k] = W'($urandom);
    send_frame(1'b0, -1, "ssel_count");
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < SZ; k++) tx_bytes[k] = W'($urandom);
    send_frame(1'b0, 3, "start_busy");
  endtask

  task automatic test_reset_mid_frame();
    int r0, d0;
    for (int k = 0; k < SZ; k++) tx_bytes[k] = W'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      byte_in    = tx_bytes[k];
      byte_valid = 1'b1;
      wait_ready("reset_mid");
      @(negedge clk);
    end
    byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    r0 = rdv_cnt; d0 = done_pulses;
    rst = 1'b1;
    #1;
    total += 3;
    if (ssel !== 1'b0)       begin bad++; $display("FAIL reset_mid_ssel got=%b required=0", ssel); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_mid_busy got=%b required=0", busy); end
    if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_mid_byte_ready got=%b required=0", byte_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    total += 2;
    if (rdv_cnt != r0)     begin bad++; $display("FAIL reset_mid_rd_valid got=%0d required=0", rdv_cnt - r0); end
    if (done_pulses != d0) begin bad++; $display("FAIL reset_mid_done got=%0d required=0", done_pulses - d0); end
    // Ten whole bytes plus the top four bits of byte 10 reached the chain.
    for (int k = 0; k < 10; k++) ref_chain = {ref_chain[CW-W-1:0], tx_bytes[k]};
    ref_chain = {ref_chain[CW-5:0], tx_bytes[10][W-1:W-4]};
    for (int k = 0; k < SZ; k++) tx_bytes[k] = W'($urandom);
    send_frame(1'b0, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] first [SZ];
    int base;
    for (int k = 0; k < SZ; k++) begin tx_bytes[k] = W'($urandom); first[k] = tx_bytes[k]; end
    send_frame(1'b0, -1, "b2b_first");
    base = got_q.size();
    for (int k = 0; k < SZ; k++) tx_bytes[k] = 8'h5A;
    send_frame(1'b0, -1, "b2b_second");
    for (int k = 0; k < SZ; k++) begin
      total++;
      if (base + k >= got_q.size() || got_q[base+k] !== first[k]) begin
        bad++; $display("FAIL b2b_send_order k=%0d required=%0h", k, first[k]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_frame();
    test_stalls();
    test_ssel_count();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
